// File: rtl/ql_pkg.sv
// Shared definitions for the Q-learning run sequencer: register map, CTRL/STATUS
// bit positions, FSM encoding and reset defaults.
package ql_pkg;

    localparam logic [2:0] ADDR_CTRL        = 3'd0;
    localparam logic [2:0] ADDR_MAX_STEP    = 3'd1;
    localparam logic [2:0] ADDR_MAX_EPISODE = 3'd2;
    localparam logic [2:0] ADDR_SEED        = 3'd3;
    localparam logic [2:0] ADDR_STATUS      = 3'd4;
    localparam logic [2:0] ADDR_EPISODE     = 3'd5;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_RESUME = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_CLR    = 3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_TIMEOUT  = 2;
    localparam int STAT_ABORTED  = 3;
    localparam int STAT_WR_ERR   = 4;
    localparam int STAT_STATE_LO = 5;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Last ARM cycle index: the control unit gets four cycles to leave idle.
    localparam logic [1:0] ARM_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic wr_err;
        logic aborted;
        logic timeout;
        logic done;
    } sticky_t;

endpackage

// File: rtl/ql_watchdog.sv
// Saturating cycle counter with synchronous clear and a limit-reached flag.
module ql_watchdog #(
    parameter int              WD_W     = 32,
    parameter logic [WD_W-1:0] WD_LIMIT = 32'd50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [WD_W-1:0] count;

    assign hit = (count == WD_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !hit) begin
            count <= count + {{(WD_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/ql_run_sequencer.sv
// Host-side sequencer for the Q-learning control unit: register file, launch/abort
// FSM, watchdog supervision and sticky status for software polling.
module ql_run_sequencer
    import ql_pkg::*;
#(
    parameter int              WD_W     = 32,
    parameter logic [WD_W-1:0] WD_LIMIT = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wr,
    input  logic [2:0]  reg_addr,
    input  logic [15:0] reg_wdata,
    output logic [15:0] reg_rdata,
    output logic        cu_start,
    output logic        cu_active,
    output logic [15:0] cu_max_step,
    output logic [15:0] cu_max_episode,
    output logic [15:0] cu_seed,
    input  logic        cu_idle,
    input  logic        cu_finish,
    input  logic [15:0] cu_ec,
    output logic        irq
);

    state_t      state, state_nxt;
    sticky_t     sticky_q, set_flags;
    logic        clr_sticky, launch, launch_resume;
    logic        resume_q;
    logic [1:0]  arm_cnt_q;
    logic        irq_q;
    logic        wd_clr, wd_en, wd_hit;
    logic        busy;

    logic ctrl_wr, go, resume, abort, clr;
    logic cfg_wr, cfg_open;

    assign ctrl_wr  = reg_wr && (reg_addr == ADDR_CTRL);
    assign go       = ctrl_wr && reg_wdata[CTRL_GO];
    assign resume   = ctrl_wr && reg_wdata[CTRL_RESUME];
    assign abort    = ctrl_wr && reg_wdata[CTRL_ABORT];
    assign clr      = ctrl_wr && reg_wdata[CTRL_CLR];
    assign cfg_wr   = reg_wr && (reg_addr == ADDR_MAX_STEP || reg_addr == ADDR_MAX_EPISODE ||
                                 reg_addr == ADDR_SEED);
    assign cfg_open = (state == ST_IDLE) || (state == ST_DONE);

    ql_watchdog #(
        .WD_W     (WD_W),
        .WD_LIMIT (WD_LIMIT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .en    (wd_en),
        .hit   (wd_hit)
    );

    // Restart the count on every launch, and again when RUN times out so DRAIN
    // gets its own full budget.
    assign wd_clr = (state == ST_ARM) || (state == ST_RUN && wd_hit);
    assign wd_en  = (state == ST_RUN) || (state == ST_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt     = state;
        set_flags     = '0;
        clr_sticky    = 1'b0;
        launch        = 1'b0;
        launch_resume = 1'b0;

        if (cfg_wr && !cfg_open) set_flags.wr_err = 1'b1;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (go || resume) begin
                    if ((go && resume) || !cu_idle) begin
                        set_flags.wr_err = 1'b1;
                    end else begin
                        state_nxt     = ST_ARM;
                        launch        = 1'b1;
                        launch_resume = resume;
                    end
                end
                if (clr) begin
                    clr_sticky = 1'b1;
                    if (!launch) state_nxt = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (cu_finish) begin
                    state_nxt = ST_DRAIN;
                end else if (abort) begin
                    state_nxt         = ST_DRAIN;
                    set_flags.aborted = 1'b1;
                end else if (!cu_idle) begin
                    state_nxt = ST_RUN;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_nxt         = ST_IDLE;
                    set_flags.timeout = 1'b1;
                end
            end
            ST_RUN: begin
                if (cu_finish) begin
                    state_nxt = ST_DRAIN;
                end else if (abort) begin
                    state_nxt         = ST_DRAIN;
                    set_flags.aborted = 1'b1;
                end else if (wd_hit) begin
                    state_nxt         = ST_DRAIN;
                    set_flags.timeout = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cu_idle) begin
                    state_nxt = ST_DONE;
                end else if (wd_hit) begin
                    state_nxt         = ST_DONE;
                    set_flags.timeout = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (state == ST_DRAIN && state_nxt == ST_DONE &&
            !(sticky_q.aborted || sticky_q.timeout || set_flags.aborted || set_flags.timeout))
            set_flags.done = 1'b1;
    end

    always_comb begin
        cu_start  = 1'b0;
        cu_active = 1'b0;
        if (state == ST_ARM || state == ST_RUN) begin
            cu_start  = !resume_q;
            cu_active = resume_q;
        end
        busy = (state == ST_ARM) || (state == ST_RUN) || (state == ST_DRAIN);
        irq  = irq_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cu_max_step    <= '0;
            cu_max_episode <= '0;
            cu_seed        <= DEFAULT_SEED;
            sticky_q       <= '0;
            resume_q       <= 1'b0;
            arm_cnt_q      <= '0;
            irq_q          <= 1'b0;
        end else begin
            if (cfg_wr && cfg_open) begin
                if (reg_addr == ADDR_MAX_STEP)    cu_max_step    <= reg_wdata;
                if (reg_addr == ADDR_MAX_EPISODE) cu_max_episode <= reg_wdata;
                if (reg_addr == ADDR_SEED)        cu_seed        <= reg_wdata;
            end
            sticky_q  <= (clr_sticky ? '0 : sticky_q) | set_flags;
            if (launch) resume_q <= launch_resume;
            arm_cnt_q <= (state == ST_ARM) ? arm_cnt_q + 2'd1 : 2'd0;
            irq_q     <= (state_nxt == ST_DONE && state != ST_DONE) ||
                         (state == ST_ARM && state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        reg_rdata = '0;
        unique case (reg_addr)
            ADDR_MAX_STEP:    reg_rdata = cu_max_step;
            ADDR_MAX_EPISODE: reg_rdata = cu_max_episode;
            ADDR_SEED:        reg_rdata = cu_seed;
            ADDR_STATUS: begin
                reg_rdata[STAT_BUSY]                       = busy;
                reg_rdata[STAT_DONE]                       = sticky_q.done;
                reg_rdata[STAT_TIMEOUT]                    = sticky_q.timeout;
                reg_rdata[STAT_ABORTED]                    = sticky_q.aborted;
                reg_rdata[STAT_WR_ERR]                     = sticky_q.wr_err;
                reg_rdata[STAT_STATE_LO+2:STAT_STATE_LO]   = state;
            end
            ADDR_EPISODE:     reg_rdata = cu_ec;
            default:          reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ql_run_sequencer.sv
// Directed bench for ql_run_sequencer: register vectors plus hand-driven
// control-unit sequences for launch, write lockout, abort, watchdog and reset.
module tb_ql_run_sequencer;
    import ql_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr = 1'b0;
    logic [2:0]  reg_addr = 3'd0;
    logic [15:0] reg_wdata = 16'd0;
    logic [15:0] reg_rdata;
    logic        cu_start, cu_active, irq;
    logic [15:0] cu_max_step, cu_max_episode, cu_seed;
    logic        cu_idle = 1'b1;
    logic        cu_finish = 1'b0;
    logic [15:0] cu_ec = 16'h0007;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ql_run_sequencer #(.WD_W(32), .WD_LIMIT(32'd100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_wr         (reg_wr),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_rdata      (reg_rdata),
        .cu_start       (cu_start),
        .cu_active      (cu_active),
        .cu_max_step    (cu_max_step),
        .cu_max_episode (cu_max_episode),
        .cu_seed        (cu_seed),
        .cu_idle        (cu_idle),
        .cu_finish      (cu_finish),
        .cu_ec          (cu_ec),
        .irq            (irq)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [15:0] exp_step;
        logic [15:0] exp_ep;
        logic [15:0] exp_seed;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_wr = 1'b0; reg_wdata = 16'd0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
    endtask

    task automatic chk_status(input string name, input logic [15:0] exp);
        logic [15:0] v;
        rd(ADDR_STATUS, v);
        check(name, {16'd0, v}, {16'd0, exp});
    endtask

    // Ticks until STATUS.state leaves `from`; n is the number of ticks taken.
    task automatic ticks_until_leave(input logic [2:0] from, input int max, output int n);
        logic [15:0] v;
        n = 0;
        do begin
            tick();
            n++;
            rd(ADDR_STATUS, v);
        end while (v[7:5] == from && n < max);
    endtask

    initial begin
        logic [15:0] v;
        int n;

        vecs[0] = '{1'b0, ADDR_SEED,        16'h0000, 16'hACE1, 16'd0, 16'd0, 16'hACE1};
        vecs[1] = '{1'b0, ADDR_STATUS,      16'h0000, 16'h0000, 16'd0, 16'd0, 16'hACE1};
        vecs[2] = '{1'b1, ADDR_MAX_STEP,    16'd5,    16'd5,    16'd5, 16'd0, 16'hACE1};
        vecs[3] = '{1'b1, ADDR_MAX_EPISODE, 16'd3,    16'd3,    16'd5, 16'd3, 16'hACE1};
        vecs[4] = '{1'b1, ADDR_SEED,        16'h1234, 16'h1234, 16'd5, 16'd3, 16'h1234};
        vecs[5] = '{1'b0, 3'd6,             16'h0000, 16'h0000, 16'd5, 16'd3, 16'h1234};
        vecs[6] = '{1'b1, 3'd7,             16'hFFFF, 16'h0000, 16'd5, 16'd3, 16'h1234};
        vecs[7] = '{1'b0, ADDR_EPISODE,     16'h0000, 16'h0007, 16'd5, 16'd3, 16'h1234};
        vecs[8] = '{1'b1, ADDR_STATUS,      16'hFFFF, 16'h0000, 16'd5, 16'd3, 16'h1234};

        // Reset state
        tick();
        check("reset_cu_start", {31'd0, cu_start}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Register vectors in ST_IDLE
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, v);
            check($sformatf("vec%0d_rdata", i), {16'd0, v}, {16'd0, vecs[i].exp_rd});
            check($sformatf("vec%0d_cfg", i), {cu_max_step, cu_max_episode},
                  {vecs[i].exp_step, vecs[i].exp_ep});
            check($sformatf("vec%0d_seed", i), {16'd0, cu_seed}, {16'd0, vecs[i].exp_seed});
        end

        // 1: normal run
        wr(ADDR_CTRL, 16'h0001);
        check("t1_start_latency", {31'd0, cu_start}, 32'd1);
        chk_status("t1_arm", 16'h0021);
        cu_idle = 1'b0;
        tick();
        chk_status("t1_run", 16'h0041);
        for (int e = 1; e <= 3; e++) begin
            cu_ec = 16'(e);
            tick();
            check($sformatf("t1_start_hold%0d", e), {30'd0, cu_start, cu_active}, 32'd2);
        end
        rd(ADDR_EPISODE, v);
        check("t1_episode", {16'd0, v}, 32'd3);
        cu_finish = 1'b1;
        tick();
        cu_finish = 1'b0;
        check("t1_drain_start", {30'd0, cu_start, cu_active}, 32'd0);
        chk_status("t1_drain", 16'h0061);
        cu_idle = 1'b1;
        tick();
        check("t1_irq_on", {31'd0, irq}, 32'd1);
        chk_status("t1_done", 16'h0082);
        tick();
        check("t1_irq_off", {31'd0, irq}, 32'd0);

        // 2: config write during RUN is locked out
        wr(ADDR_CTRL, 16'h0008);
        chk_status("t2_clr", 16'h0000);
        wr(ADDR_CTRL, 16'h0001);
        cu_idle = 1'b0;
        tick();
        wr(ADDR_MAX_EPISODE, 16'd9);
        check("t2_ep_locked", {16'd0, cu_max_episode}, 32'd3);
        chk_status("t2_wr_err", 16'h0051);
        cu_finish = 1'b1;
        tick();
        cu_finish = 1'b0;
        cu_idle = 1'b1;
        tick();
        chk_status("t2_done", 16'h0092);

        // 3: abort mid-run
        wr(ADDR_CTRL, 16'h0008);
        wr(ADDR_CTRL, 16'h0001);
        cu_idle = 1'b0;
        tick();
        tick();
        wr(ADDR_CTRL, 16'h0004);
        check("t3_abort_start", {31'd0, cu_start}, 32'd0);
        chk_status("t3_drain", 16'h0069);
        tick();
        tick();
        chk_status("t3_drain_hold", 16'h0069);
        cu_idle = 1'b1;
        tick();
        check("t3_irq", {31'd0, irq}, 32'd1);
        chk_status("t3_done", 16'h0088);

        // 4: watchdog timeout in RUN then in DRAIN (count runs 0..WD_LIMIT)
        wr(ADDR_CTRL, 16'h0008);
        wr(ADDR_CTRL, 16'h0001);
        cu_idle = 1'b0;
        tick();
        chk_status("t4_run", 16'h0041);
        ticks_until_leave(3'd2, 400, n);
        check("t4_run_len", {31'd0, n >= 100 && n <= 101}, 32'd1);
        chk_status("t4_drain_timeout", 16'h0065);
        ticks_until_leave(3'd3, 400, n);
        check("t4_drain_len", {31'd0, n >= 100 && n <= 101}, 32'd1);
        check("t4_irq", {31'd0, irq}, 32'd1);
        chk_status("t4_done", 16'h0084);
        cu_idle = 1'b1;

        // 5: launch refused while busy/ambiguous, then RESUME, then ARM timeout
        wr(ADDR_CTRL, 16'h0008);
        wr(ADDR_CTRL, 16'h0003);
        chk_status("t5_go_resume", 16'h0010);
        wr(ADDR_CTRL, 16'h0008);
        cu_idle = 1'b0;
        wr(ADDR_CTRL, 16'h0001);
        check("t5_no_start", {30'd0, cu_start, cu_active}, 32'd0);
        chk_status("t5_not_idle", 16'h0010);
        cu_idle = 1'b1;
        wr(ADDR_CTRL, 16'h0002);
        check("t5_resume", {30'd0, cu_start, cu_active}, 32'd1);
        tick();
        tick();
        tick();
        chk_status("t5_arm_wait", 16'h0031);
        tick();
        chk_status("t5_arm_timeout", 16'h0014);
        check("t5_req_dropped", {30'd0, cu_start, cu_active}, 32'd0);

        // 6: asynchronous reset mid-run
        wr(ADDR_CTRL, 16'h0008);
        wr(ADDR_CTRL, 16'h0001);
        cu_idle = 1'b0;
        tick();
        tick();
        check("t6_running", {31'd0, cu_start}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {29'd0, cu_start, cu_active, irq}, 32'd0);
        rd(ADDR_SEED, v);
        check("t6_seed", {16'd0, v}, 32'h0000ACE1);
        chk_status("t6_status", 16'h0000);
        rd(ADDR_MAX_STEP, v);
        check("t6_step", {16'd0, v}, 32'd0);
        cu_idle = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk_status("t6_after", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ql_run_sequencer.md
Name: ql_run_sequencer

Overview:
- Host-side counterpart of the Q-learning control unit. Drives the control unit's `start`, `active`, `max_step`, `max_episode` and `seed` inputs.
- Observes the control unit's `idle`, `finish` and episode-count outputs.
- Exposes a small register interface to the processing system so software can configure, launch, abort and poll a training run.
- Adds a watchdog and sticky status so software never hangs on a lost `finish`.

Parameters:
- WD_W, 32, width of watchdog cycle counter
- WD_LIMIT, 32'd50_000_000, cycles in RUN or DRAIN without completion before timeout

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- reg_wr  in  1  register write strobe, one cycle
- reg_addr  in  3  register address (write and read)
- reg_wdata  in  16  write data
- reg_rdata  out  16  combinational read data for reg_addr
- cu_start  out  1  start request to control unit
- cu_active  out  1  resume (skip-init) request to control unit
- cu_max_step  out  16  step limit
- cu_max_episode  out  16  episode limit
- cu_seed  out  16  LFSR seed
- cu_idle  in  1  control unit in idle state
- cu_finish  in  1  control unit reached done
- cu_ec  in  16  control unit episode counter
- irq  out  1  one-cycle pulse on run completion, abort or timeout

Behaviour:
Register map:
- 0 CTRL, write-only. bit0 GO, bit1 RESUME, bit2 ABORT, bit3 CLR. All bits self-clear.
- 1 MAX_STEP.
- 2 MAX_EPISODE.
- 3 SEED.
- 4 STATUS, read-only:
  - bit0 busy
  - bit1 done (sticky)
  - bit2 timeout (sticky)
  - bit3 aborted (sticky)
  - bit4 wr_err (sticky)
  - bits7:5 FSM state
- 5 EPISODE: live cu_ec, read-only.
- 6, 7: read 0.

Reset (rst_n low, asynchronous):
- State ST_IDLE.
- cu_start, cu_active, irq = 0.
- MAX_STEP = 0, MAX_EPISODE = 0, SEED = 16'hACE1.
- All sticky bits and the watchdog = 0.

Configuration registers:
- Drive cu_* directly.
- Writable only in ST_IDLE or ST_DONE.
- A write in any other state is ignored and sets wr_err.

FSM, transitions evaluated each clk:
- ST_IDLE
  - GO with cu_idle = 1 → ST_ARM. cu_start = 1, cu_active = 0.
  - RESUME with cu_idle = 1 → ST_ARM. cu_active = 1, cu_start = 0.
  - GO and RESUME in the same write → wr_err, stay in ST_IDLE.
  - GO or RESUME while cu_idle = 0 → wr_err, stay in ST_IDLE.
- ST_ARM
  - Hold the request.
  - When cu_idle falls → ST_RUN and clear the watchdog.
  - If cu_idle is still high after 4 cycles → ST_IDLE, set timeout, drop the request.
- ST_RUN
  - Hold the request high; the control unit loops episodes while cu_start is high.
  - Watchdog increments each cycle.
  - cu_finish = 1 → ST_DRAIN, deassert cu_start and cu_active.
  - ABORT → ST_DRAIN, deassert the request, set aborted.
  - Watchdog == WD_LIMIT → ST_DRAIN, set timeout.
- ST_DRAIN
  - Both requests low.
  - Wait for cu_idle = 1, then → ST_DONE.
  - Watchdog keeps running; reaching WD_LIMIT a second time → ST_DONE with timeout set.
- ST_DONE
  - Set done unless aborted or timeout is set. Pulse irq for 1 cycle on entry.
  - GO or RESUME behaves as in ST_IDLE.
  - CLR → ST_IDLE, clears all sticky bits.
- Global rules:
  - CLR in ST_IDLE clears sticky bits.
  - CLR in other states is ignored.
  - ABORT outside ST_RUN and ST_ARM is ignored.
  - busy = state is ST_ARM, ST_RUN or ST_DRAIN.
  - Watchdog saturates at WD_LIMIT; it never wraps.
  - cu_finish seen in ST_ARM → treat as ST_RUN then finish (go straight to ST_DRAIN).
- Latency: GO write to cu_start high is 1 cycle.

Decomposition:
- Shared package `ql_pkg`:
  - register address constants (`ADDR_CTRL` … `ADDR_EPISODE`)
  - CTRL bit indices
  - FSM state encoding (3-bit)
  - STATUS bit indices
  - default SEED
- One natural sub-module: `ql_watchdog`, a saturating counter with clear, enable and limit compare.
- The register file and FSM stay in the top level.

Test Plan:
1. Write MAX_STEP = 5, MAX_EPISODE = 3, SEED = 16'h1234, then GO, with a CU model that drops idle after 1 cycle and pulses finish after 3 episodes → cu_start high from cycle after GO until finish, then DRAIN, DONE; STATUS = done|state; irq exactly 1 cycle.
2. Write MAX_EPISODE during ST_RUN → cu_max_episode unchanged, STATUS.wr_err = 1, run completes normally.
3. ABORT mid-run → cu_start low next cycle, DONE reached after cu_idle, aborted = 1, done = 0.
4. WD_LIMIT = 100 and CU never finishes → after 100 RUN cycles, DRAIN with timeout = 1; if CU never idles, DONE after another 100 cycles.
5. GO with cu_idle held 0 → wr_err, stays in ST_IDLE, cu_start stays 0; then RESUME with idle = 1 → cu_active = 1, cu_start = 0.
6. Assert rst_n low mid-run → all outputs 0 immediately (asynchronous), SEED reads 16'hACE1, STATUS reads 0.
